// File: rtl/montgomery_exp_pkg.sv
`default_nettype none
// ============================================================================
// montgomery_exp_pkg : shared width default plus op-state and handshake-phase encodings
// Rev 1.0
// ============================================================================
package montgomery_exp_pkg;

  localparam int unsigned c_N = 512;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_CONV  = 3'd1;
  localparam logic [2:0] c_ST_SQR   = 3'd2;
  localparam logic [2:0] c_ST_MUL   = 3'd3;
  localparam logic [2:0] c_ST_NEXT  = 3'd4;
  localparam logic [2:0] c_ST_FINAL = 3'd5;

  // NEXT is resolved inside the SQR/MUL capture cycle so ops run back to back.
  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_CONV  = c_ST_CONV,
    ST_SQR   = c_ST_SQR,
    ST_MUL   = c_ST_MUL,
    ST_NEXT  = c_ST_NEXT,
    ST_FINAL = c_ST_FINAL
  } state_t;

  localparam logic [1:0] c_PH_IDLE = 2'd0;
  localparam logic [1:0] c_PH_RST  = 2'd1;
  localparam logic [1:0] c_PH_GO   = 2'd2;
  localparam logic [1:0] c_PH_WAIT = 2'd3;

  typedef enum logic [1:0] {
    PH_IDLE = c_PH_IDLE,
    PH_RST  = c_PH_RST,
    PH_GO   = c_PH_GO,
    PH_WAIT = c_PH_WAIT
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/montgomery_exp_if.sv
`default_nettype none
// ============================================================================
// montgomery_exp_if : bus between the exponentiation controller and the multiplier
// Rev 1.0
// ============================================================================
interface montgomery_exp_if
  import montgomery_exp_pkg::*;
#(
  parameter int N = c_N
);
  logic         mul_resetn;
  logic         mul_start;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_m;
  logic [N-1:0] mul_result;
  logic         mul_done;

  modport master (
    output mul_resetn, mul_start, mul_a, mul_b, mul_m,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_resetn, mul_start, mul_a, mul_b, mul_m,
    output mul_result, mul_done
  );
endinterface
`default_nettype wire

// File: rtl/montgomery_exp_handshake.sv
`default_nettype none
// ============================================================================
// mont_handshake : RST/GO/WAIT sequencing of one multiplier op per issue pulse
// Rev 1.0
// ============================================================================
module mont_handshake
  import montgomery_exp_pkg::*;
(
  input  wire logic clk,
  input  wire logic resetn,
  input  wire logic i_issue,
  input  wire logic i_mulDone,
  output logic      o_mulResetn,
  output logic      o_mulStart,
  output logic      o_capture
);
  phase_t r_phase;
  logic   r_mulResetn;
  logic   r_mulStart;
  logic   r_armed;

  // done only counts once it has been seen low after GO, so a stale level never captures
  assign o_capture   = (r_phase == PH_WAIT) && i_mulDone && r_armed;
  assign o_mulResetn = r_mulResetn;
  assign o_mulStart  = r_mulStart;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_phase     <= PH_IDLE;
      r_mulResetn <= 1'b0;
      r_mulStart  <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_mulStart <= 1'b0;
      if (i_issue) begin
        r_phase     <= PH_RST;
        r_mulResetn <= 1'b0;
        r_armed     <= 1'b0;
      end else begin
        case (r_phase)
          PH_RST: begin
            r_phase     <= PH_GO;
            r_mulResetn <= 1'b1;
            r_mulStart  <= 1'b1;
          end
          PH_GO: begin
            r_phase <= PH_WAIT;
            r_armed <= !i_mulDone;
          end
          PH_WAIT: begin
            if (o_capture) begin
              r_phase     <= PH_IDLE;
              r_mulResetn <= 1'b0;
            end else if (!i_mulDone) begin
              r_armed <= 1'b1;
            end
          end
          default: r_mulResetn <= 1'b0;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/montgomery_exp.sv
`default_nettype none
// ============================================================================
// montgomery_exp : X^E mod M by left-to-right square-and-multiply over a Montgomery multiplier
// Rev 1.0
// ============================================================================
module montgomery_exp
  import montgomery_exp_pkg::*;
#(
  parameter int N     = c_N,
  parameter int LEN_W = 10
)(
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             start,
  input  wire logic [N-1:0]     in_x,
  input  wire logic [N-1:0]     in_e,
  input  wire logic [LEN_W-1:0] in_elen,
  input  wire logic [N-1:0]     in_m,
  input  wire logic [N-1:0]     in_r,
  input  wire logic [N-1:0]     in_r2,
  output logic      [N-1:0]     result,
  output logic                  done,
  output logic                  busy,
  montgomery_exp_if.master      mul
);
  localparam logic [LEN_W-1:0] c_NLEN = LEN_W'(N);
  localparam logic [N-1:0]     c_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [N-1:0]     r_x, r_e, r_m, r_r, r_r2, r_accA, r_xt;
  logic [LEN_W-1:0] r_idx;
  logic             r_zeroLen;

  logic [LEN_W-1:0] w_elen, w_shamt;
  logic [N-1:0]     w_opA, w_opB;
  logic             w_capture, w_issue, w_lastBit;

  assign w_elen    = (in_elen > c_NLEN) ? c_NLEN : in_elen;
  assign w_shamt   = c_NLEN - w_elen;
  assign w_lastBit = (r_idx == '0);
  assign w_issue   = ((r_state == ST_IDLE) && start) || (w_capture && (r_state != ST_FINAL));

  mont_handshake u_handshake (
    .clk         (clk),
    .resetn      (resetn),
    .i_issue     (w_issue),
    .i_mulDone   (mul.mul_done),
    .o_mulResetn (mul.mul_resetn),
    .o_mulStart  (mul.mul_start),
    .o_capture   (w_capture)
  );

  always_comb begin
    w_opA = '0;
    w_opB = '0;
    case (r_state)
      ST_CONV:  begin w_opA = r_x;    w_opB = r_r2;   end
      ST_SQR:   begin w_opA = r_accA; w_opB = r_accA; end
      ST_MUL:   begin w_opA = r_accA; w_opB = r_xt;   end
      ST_FINAL: begin w_opA = r_accA; w_opB = c_ONE;  end
      default:  ;
    endcase
  end

  assign mul.mul_a = w_opA;
  assign mul.mul_b = w_opB;
  assign mul.mul_m = r_m;

  // Exponent is pre-aligned so the bit being scanned is always r_e[N-1].
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_e       <= '0;
      r_m       <= '0;
      r_r       <= '0;
      r_r2      <= '0;
      r_accA    <= '0;
      r_xt      <= '0;
      r_idx     <= '0;
      r_zeroLen <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_x       <= in_x;
          r_e       <= in_e << w_shamt;
          r_m       <= in_m;
          r_r       <= in_r;
          r_r2      <= in_r2;
          r_idx     <= w_elen - LEN_W'(1);
          r_zeroLen <= (w_elen == '0);
          done      <= 1'b0;
          busy      <= 1'b1;
          r_state   <= ST_CONV;
        end
        ST_CONV: if (w_capture) begin
          r_xt    <= mul.mul_result;
          r_accA  <= r_r;
          r_state <= r_zeroLen ? ST_FINAL : ST_SQR;
        end
        ST_SQR: if (w_capture) begin
          r_accA <= mul.mul_result;
          if (r_e[N-1]) begin
            r_state <= ST_MUL;
          end else if (w_lastBit) begin
            r_state <= ST_FINAL;
          end else begin
            r_idx   <= r_idx - LEN_W'(1);
            r_e     <= r_e << 1;
            r_state <= ST_SQR;
          end
        end
        ST_MUL: if (w_capture) begin
          r_accA <= mul.mul_result;
          if (w_lastBit) begin
            r_state <= ST_FINAL;
          end else begin
            r_idx   <= r_idx - LEN_W'(1);
            r_e     <= r_e << 1;
            r_state <= ST_SQR;
          end
        end
        ST_FINAL: if (w_capture) begin
          r_accA  <= mul.mul_result;
          result  <= mul.mul_result;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
